// File: rtl/wb_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// Wishbone memory arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Widest arbiter supported; the pick function works on this width and
    // callers zero-extend their request vector.
    localparam int MAX_MASTERS = 8;

    // First requester at or after ptr in cyclic order over n masters,
    // returned one-hot (all zero when nobody requests).
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             ptr,
        input int                     n
    );
        logic [MAX_MASTERS-1:0] grant;
        logic                   found;
        logic [2:0]             slot;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            slot = 3'((int'(ptr) + k) % n);
            if (k < n && !found && req[slot]) begin
                grant[slot] = 1'b1;
                found       = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/wb_mem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: request vector and pointer
// in, one-hot grant and its binary index out.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IW          = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_ptr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IW-1:0]          o_idx
);

    logic [MAX_MASTERS-1:0] w_req_pad;
    logic [MAX_MASTERS-1:0] w_pick;

    assign w_req_pad = MAX_MASTERS'(i_req);
    assign w_pick    = rr_pick(w_req_pad, 3'(i_ptr), NUM_MASTERS);
    assign o_grant   = w_pick[NUM_MASTERS-1:0];

    // Encode the one-hot pick into the index the top stores for muxing.
    always_comb begin
        o_idx = '0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            if (w_pick[k]) begin
                o_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the single external memory
// port. The grant follows the winning master's cyc, so bursts and locked
// sequences are never split. Optional stalled-slave watchdog is enabled by
// defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_sys,
    input  logic [NUM_MASTERS-1:0][AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS-1:0][DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS-1:0][2:0]      m_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]      m_bte_i,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic [NUM_MASTERS-1:0]           m_rty_o,
    output logic [DW-1:0]                    m_dat_o,
    output logic [AW-1:0]                    s_adr_o,
    output logic [DW-1:0]                    s_dat_o,
    output logic [DW/8-1:0]                  s_sel_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [2:0]                       s_cti_o,
    output logic [1:0]                       s_bte_o,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    input  logic                             s_rty_i,
    input  logic [DW-1:0]                    s_dat_i,
    output logic [NUM_MASTERS-1:0]           grant_o
);

    localparam int IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_mem_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t              r_state;
    logic [NUM_MASTERS-1:0]  r_grant;
    logic [IW-1:0]           r_gidx;
    logic [IW-1:0]           r_rr_ptr;

    logic [NUM_MASTERS-1:0]  w_pick_grant;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_gnt_cyc;
    logic                    w_cyc_raw;
    logic                    w_stb_raw;
    logic                    w_timeout;

    wb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_rr_pick (
        .i_req   (m_cyc_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_gnt_cyc = m_cyc_i[r_gidx];

    // Arbitration FSM: latch the winner on any cyc, release when its cyc drops.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (|m_cyc_i) begin
                        r_state <= ARB_GRANT;
                        r_grant <= w_pick_grant;
                        r_gidx  <= w_pick_idx;
                    end
                end
                ARB_GRANT: begin
                    // Always pass through IDLE so the slave sees cyc drop.
                    if (!w_gnt_cyc) begin
                        r_state  <= ARB_IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= (r_gidx == IW'(NUM_MASTERS - 1)) ? '0 : r_gidx + IW'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Slave-side mux; an all-zero grant (IDLE or reset) drives everything low.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        w_cyc_raw = 1'b0;
        w_stb_raw = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                s_adr_o   = m_adr_i[k];
                s_dat_o   = m_dat_i[k];
                s_sel_o   = m_sel_i[k];
                s_we_o    = m_we_i[k];
                s_cti_o   = m_cti_i[k];
                s_bte_o   = m_bte_i[k];
                w_cyc_raw = m_cyc_i[k];
                w_stb_raw = m_stb_i[k];
            end
        end
    end

    assign s_cyc_o = w_cyc_raw;
    assign s_stb_o = w_stb_raw & ~w_timeout;

    // Route slave terminations only to the granted master.
    always_comb begin
        m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
        m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_timeout}};
        m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
    end

    // Read data is shared; each master qualifies it with its own ack.
    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wdt_cnt;
    logic             w_term;

    assign w_term    = s_ack_i | s_err_i | s_rty_i;
    // A real termination in the last cycle wins over the watchdog.
    assign w_timeout = w_stb_raw && !w_term && (r_wdt_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: count unanswered strobe cycles, clear on any termination.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            r_wdt_cnt <= '0;
        end else if (r_state == ARB_IDLE || w_term || w_timeout) begin
            r_wdt_cnt <= '0;
        end else if (w_stb_raw) begin
            r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter (two masters).
// Build with WB_ARB_TIMEOUT_EN defined to exercise the watchdog instead of
// the stalled-slave hang.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                     clk = 1'b0;
    logic                     rst_sys;
    logic [N-1:0][AW-1:0]     m_adr;
    logic [N-1:0][DW-1:0]     m_dat;
    logic [N-1:0][DW/8-1:0]   m_sel;
    logic [N-1:0]             m_cyc, m_stb, m_we;
    logic [N-1:0][2:0]        m_cti;
    logic [N-1:0][1:0]        m_bte;
    logic [N-1:0]             m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]            m_dat_o;
    logic [AW-1:0]            s_adr_o;
    logic [DW-1:0]            s_dat_o;
    logic [DW/8-1:0]          s_sel_o;
    logic                     s_cyc_o, s_stb_o, s_we_o;
    logic [2:0]               s_cti_o;
    logic [1:0]               s_bte_o;
    logic                     s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0]            s_dat_i;
    logic [N-1:0]             grant_o;

    int checks = 0;
    int errors = 0;

    wb_mem_arbiter #(
        .NUM_MASTERS    (N),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .rst_sys (rst_sys),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_cti_i (m_cti),
        .m_bte_i (m_bte),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .m_dat_o (m_dat_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_cti_o (s_cti_o),
        .s_bte_o (s_bte_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int err_cnt;
        int err_at;
        logic seen_err;

        rst_sys = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cyc = '0; m_stb = '0; m_we = '0;
        m_cti = '0; m_bte = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;

        // Reset: outputs low, terminations dropped
        repeat (2) @(posedge clk);
        #1;
        s_ack_i = 1'b1;
        #1;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_ack_drop", m_ack_o, 0);
        s_ack_i = 1'b0;
        rst_sys = 1'b0;
        tick(); tick();
        #1;
        chk("idle_s_cyc", s_cyc_o, 0);
        chk("idle_s_we", s_we_o, 0);
        chk("idle_grant", grant_o, 0);
        chk("idle_err", m_err_o, 0);

        // m0 single read
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0100; m_sel[0] = 4'hF;
        #1;
        chk("t2_latency", s_cyc_o, 0);
        tick();
        #1;
        chk("t2_grant", grant_o, 2'b01);
        chk("t2_s_cyc", s_cyc_o, 1);
        chk("t2_s_stb", s_stb_o, 1);
        chk("t2_s_adr", s_adr_o, 32'h0000_0100);
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("t2_ack", m_ack_o, 2'b01);
        chk("t2_rdata", m_dat_o, 32'hDEAD_BEEF);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b0;
        #1;
        chk("t2_cyc_follow", s_cyc_o, 0);
        chk("t2_grant_hold", grant_o, 2'b01);
        tick();
        #1;
        chk("t2_release", grant_o, 0);

        // Both request from reset: m0 first, then m1 after one IDLE cycle
        rst_sys = 1'b1;
        tick();
        rst_sys = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr[0] = 32'h10; m_adr[1] = 32'h20;
        m_we[1] = 1'b1; m_dat[1] = 32'hCAFE_0001; m_sel[1] = 4'b0011;
        tick();
        #1;
        chk("t3_first_m0", grant_o, 2'b01);
        chk("t3_adr_m0", s_adr_o, 32'h10);
        chk("t3_we_m0", s_we_o, 0);
        s_ack_i = 1'b1;
        #1;
        chk("t3_ack_m0_only", m_ack_o, 2'b01);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b0;
        tick();
        #1;
        chk("t3_turnaround", grant_o, 0);
        chk("t3_turn_cyc", s_cyc_o, 0);
        tick();
        #1;
        chk("t3_second_m1", grant_o, 2'b10);
        chk("t3_adr_m1", s_adr_o, 32'h20);
        chk("t3_we_m1", s_we_o, 1);
        chk("t3_wdat_m1", s_dat_o, 32'hCAFE_0001);
        chk("t3_sel_m1", s_sel_o, 4'b0011);
        s_ack_i = 1'b1;
        #1;
        chk("t3_ack_m1", m_ack_o, 2'b10);
        s_ack_i = 1'b0; s_err_i = 1'b1;
        #1;
        chk("t3_err_m1", m_err_o, 2'b10);
        s_err_i = 1'b0; s_rty_i = 1'b1;
        #1;
        chk("t3_rty_m1", m_rty_o, 2'b10);
        s_rty_i = 1'b0;
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
        tick();
        #1;
        chk("t3_release_m1", grant_o, 0);
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        #1;
        chk("t3_rr_wrap_m0", grant_o, 2'b01);
        tick();
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();

        // m1 4-beat incrementing burst while m0 waits (pointer now at m1)
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr[1] = 32'h40; m_cti[1] = CTI_INCR;
        m_adr[0] = 32'h80; m_cti[0] = CTI_CLASSIC;
        tick();
        #1;
        chk("t4_grant_m1", grant_o, 2'b10);
        for (int beat = 0; beat < 4; beat++) begin
            m_cti[1] = (beat == 3) ? CTI_EOB : CTI_INCR;
            m_adr[1] = 32'h40 + 32'(4 * beat);
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("t4_beat%0d_cti", beat), s_cti_o, (beat == 3) ? CTI_EOB : CTI_INCR);
            chk($sformatf("t4_beat%0d_adr", beat), s_adr_o, 32'h40 + 32'(4 * beat));
            chk($sformatf("t4_beat%0d_ack", beat), m_ack_o, 2'b10);
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = CTI_CLASSIC;
        #1;
        chk("t4_hold_to_end", grant_o, 2'b10);
        tick();
        #1;
        chk("t4_turnaround", grant_o, 0);
        tick();
        #1;
        chk("t4_then_m0", grant_o, 2'b01);
        chk("t4_adr_m0", s_adr_o, 32'h80);

        // m0 finishes, is re-granted alone, then reset hits mid-burst
        s_ack_i = 1'b1;
        tick();
        s_ack_i = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = CTI_INCR;
        tick();
        #1;
        chk("t5_regrant_m0", grant_o, 2'b01);
        chk("t5_cyc_before_rst", s_cyc_o, 1);
        #2;
        rst_sys = 1'b1;
        #1;
        chk("t5_rst_cyc_drop", s_cyc_o, 0);
        chk("t5_rst_stb_drop", s_stb_o, 0);
        chk("t5_rst_grant", grant_o, 0);
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        rst_sys = 1'b0;
        tick();
        #1;
        chk("t5_ptr_reset_m0", grant_o, 2'b01);
        chk("t5_cti_pass", s_cti_o, CTI_INCR);
        m_cyc = 2'b00; m_stb = 2'b00; m_cti = '0;
        tick(); tick();

        // Slave never answers
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        err_cnt = 0;
        err_at  = -1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (m_err_o[0]) begin
                err_cnt++;
                if (err_at < 0) err_at = c;
                m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
            end
            tick();
        end
        chk("wdt_pulse_count", 64'(err_cnt), 1);
        chk("wdt_pulse_cycle", 64'(err_at), 15);
`else
        seen_err = 1'b0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (m_err_o != '0) seen_err = 1'b1;
            tick();
        end
        #1;
        chk("stall_no_err", seen_err, 0);
        chk("stall_stb_held", s_stb_o, 1);
        chk("stall_grant_held", grant_o, 2'b01);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
